// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the architectural fetch PC, drives I-cache requests and
// redirects/flushes on resolved control-flow mispredicts.
module fetch_pc_sequencer #(
    parameter int unsigned     PC_W         = 36,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fetch_valid,
    output logic [PC_W-1:0]  fetch_pc,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_pc_next,
    input  logic             halt_req,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StFlush,
        StHalted
    } state_e;

    // Countdown is loaded with FLUSH_CYCLES-1 so flush stays high for exactly FLUSH_CYCLES.
    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e     state_q;
    logic [3:0] flush_left_q;

    logic [PC_W-1:0]  ex_fallthrough;
    logic             mispredict;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        ex_fallthrough = ex_pc + PC_W'(1);
        mispredict     = ex_valid && (ex_pc_next != ex_fallthrough) && (state_q != StHalted);
        accept         = fetch_valid && fetch_ready;
        cnt_inc        = (&redirect_cnt) ? redirect_cnt : redirect_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            flush_left_q <= '0;
            fetch_pc     <= RESET_PC;
            fetch_valid  <= 1'b0;
            flush        <= 1'b0;
            halted       <= 1'b0;
            redirect_cnt <= '0;
        end else if (mispredict) begin
            // Redirect wins over halt/stall/advance and drops any pending request.
            state_q      <= StFlush;
            flush_left_q <= FlushLoad;
            fetch_pc     <= ex_pc_next;
            fetch_valid  <= 1'b0;
            flush        <= 1'b1;
            redirect_cnt <= cnt_inc;
        end else begin
            case (state_q)
                StBoot: begin
                    state_q     <= StFetch;
                    fetch_valid <= !stall;
                end
                StFetch: begin
                    if (halt_req) begin
                        state_q     <= StHalted;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        if (accept) begin
                            fetch_pc <= fetch_pc + PC_W'(1);
                        end
                        // An unaccepted request stays valid even under stall.
                        fetch_valid <= (fetch_valid && !fetch_ready) || !stall;
                    end
                end
                StFlush: begin
                    if (flush_left_q == 4'd0) begin
                        state_q     <= StFetch;
                        flush       <= 1'b0;
                        fetch_valid <= !stall;
                    end else begin
                        flush_left_q <= flush_left_q - 4'd1;
                    end
                end
                StHalted: begin
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                end
                default: begin
                    state_q     <= StBoot;
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                end
            endcase
        end
    end

    a_flush_no_valid: assert property (@(posedge clk) disable iff (!rst_n)
        flush |-> !fetch_valid);

    a_halted_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        halted |-> (!fetch_valid && !flush));

    a_hold_request: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StFetch && fetch_valid && !fetch_ready && !mispredict && !halt_req)
        |=> (fetch_valid && $stable(fetch_pc)));

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed stimulus with a scoreboard of
// expected accepted fetch PCs plus per-step state checks.
module tb_fetch_pc_sequencer;

    localparam int unsigned PC_W         = 36;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned CNT_W        = 8;
    localparam logic [PC_W-1:0] MaxPc    = '1;
    localparam logic [63:0] NoExpect     = 64'hDEAD_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fetch_valid;
    logic [PC_W-1:0]  fetch_pc;
    logic             fetch_ready;
    logic             stall;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [PC_W-1:0]  ex_pc_next;
    logic             halt_req;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] redirect_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_pc_sequencer #(
        .PC_W        (PC_W),
        .RESET_PC    ('0),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_pc_next  (ex_pc_next),
        .halt_req    (halt_req),
        .flush       (flush),
        .halted      (halted),
        .redirect_cnt(redirect_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [63:0] epc,
                               input logic ef, input logic eh, input logic [63:0] ecnt);
        check($sformatf("%s.valid", tag), 64'(fetch_valid), 64'(ev));
        check($sformatf("%s.pc", tag), 64'(fetch_pc), epc);
        check($sformatf("%s.flush", tag), 64'(flush), 64'(ef));
        check($sformatf("%s.halted", tag), 64'(halted), 64'(eh));
        check($sformatf("%s.cnt", tag), 64'(redirect_cnt), ecnt);
    endtask

    // Score any handshake about to complete on the next edge, then advance one cycle.
    task automatic tick();
        logic [63:0] e;
        if (rst_n && fetch_valid && fetch_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NoExpect;
            check("accept_pc", 64'(fetch_pc), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        fetch_ready = 1'b0;
        stall       = 1'b0;
        ex_valid    = 1'b0;
        ex_pc       = '0;
        ex_pc_next  = '0;
        halt_req    = 1'b0;
        tick();
        tick();
        check_state("reset", 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);

        // Boot then sequential fetch 0..3
        rst_n       = 1'b1;
        fetch_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(i));
        drain("boot_stream", 20);
        fetch_ready = 1'b0;
        check_state("after_stream", 1'b1, 64'd4, 1'b0, 1'b0, 64'd0);

        // Backpressure at pc 5
        exp_q.push_back(64'd4);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("hold", 1'b1, 64'd5, 1'b0, 1'b0, 64'd0);
        end
        exp_q.push_back(64'd5);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        check_state("hold_release", 1'b1, 64'd6, 1'b0, 1'b0, 64'd0);

        // Stall keeps pending request, blocks new ones
        stall = 1'b1;
        tick();
        check_state("stall_pending", 1'b1, 64'd6, 1'b0, 1'b0, 64'd0);
        exp_q.push_back(64'd6);
        fetch_ready = 1'b1;
        tick();
        check_state("stall_idle", 1'b0, 64'd7, 1'b0, 1'b0, 64'd0);
        tick();
        check_state("stall_idle2", 1'b0, 64'd7, 1'b0, 1'b0, 64'd0);
        stall       = 1'b0;
        fetch_ready = 1'b0;
        tick();
        check_state("stall_release", 1'b1, 64'd7, 1'b0, 1'b0, 64'd0);

        // Mispredict 10 -> 40; pending request at 7 is dropped
        ex_valid   = 1'b1;
        ex_pc      = 36'd10;
        ex_pc_next = 36'd40;
        tick();
        ex_valid = 1'b0;
        check_state("redirect", 1'b0, 64'd40, 1'b1, 1'b0, 64'd1);
        fetch_ready = 1'b1;
        tick();
        check_state("redirect_hold", 1'b0, 64'd40, 1'b1, 1'b0, 64'd1);
        tick();
        check_state("redirect_resume", 1'b1, 64'd40, 1'b0, 1'b0, 64'd1);

        // Correct fall-through does nothing
        for (int i = 40; i < 44; i++) exp_q.push_back(64'(i));
        ex_valid   = 1'b1;
        ex_pc      = 36'd10;
        ex_pc_next = 36'd11;
        tick();
        ex_valid = 1'b0;
        drain("fallthrough_stream", 10);
        fetch_ready = 1'b0;
        check_state("fallthrough", 1'b1, 64'd44, 1'b0, 1'b0, 64'd1);

        ex_valid   = 1'b1;
        ex_pc      = MaxPc;
        ex_pc_next = '0;
        tick();
        ex_valid = 1'b0;
        check_state("wrap_fallthrough", 1'b1, 64'd44, 1'b0, 1'b0, 64'd1);

        // Second redirect in first flush cycle restarts the flush window
        ex_valid   = 1'b1;
        ex_pc      = 36'd100;
        ex_pc_next = 36'd40;
        tick();
        check_state("first_redirect", 1'b0, 64'd40, 1'b1, 1'b0, 64'd2);
        ex_pc_next = 36'd80;
        tick();
        ex_valid = 1'b0;
        check_state("second_redirect", 1'b0, 64'd80, 1'b1, 1'b0, 64'd3);
        tick();
        check_state("second_hold", 1'b0, 64'd80, 1'b1, 1'b0, 64'd3);
        tick();
        check_state("second_resume", 1'b1, 64'd80, 1'b0, 1'b0, 64'd3);

        // Mispredict beats halt; halt during flush is ignored
        ex_valid   = 1'b1;
        ex_pc      = 36'd80;
        ex_pc_next = 36'd200;
        halt_req   = 1'b1;
        tick();
        ex_valid = 1'b0;
        halt_req = 1'b0;
        check_state("mp_halt", 1'b0, 64'd200, 1'b1, 1'b0, 64'd4);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_state("halt_in_flush", 1'b1, 64'd200, 1'b0, 1'b0, 64'd4);

        // Halt alone parks the sequencer; everything but reset is ignored
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_state("halted", 1'b0, 64'd200, 1'b0, 1'b1, 64'd4);
        fetch_ready = 1'b1;
        ex_valid    = 1'b1;
        ex_pc       = '0;
        ex_pc_next  = 36'd123;
        halt_req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("halted_ignore", 1'b0, 64'd200, 1'b0, 1'b1, 64'd4);
        end
        fetch_ready = 1'b0;
        ex_valid    = 1'b0;
        halt_req    = 1'b0;
        rst_n       = 1'b0;
        tick();
        check_state("reset2", 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        rst_n = 1'b1;

        // Redirect from BOOT to top of address space, then PC wraps to 0
        ex_valid   = 1'b1;
        ex_pc      = '0;
        ex_pc_next = MaxPc;
        tick();
        ex_valid = 1'b0;
        check_state("boot_redirect", 1'b0, 64'(MaxPc), 1'b1, 1'b0, 64'd1);
        tick();
        tick();
        check_state("wrap_resume", 1'b1, 64'(MaxPc), 1'b0, 1'b0, 64'd1);
        exp_q.push_back(64'(MaxPc));
        exp_q.push_back(64'd0);
        fetch_ready = 1'b1;
        drain("wrap_stream", 10);
        fetch_ready = 1'b0;
        check_state("pc_wrap", 1'b1, 64'd1, 1'b0, 1'b0, 64'd1);

        // Redirect counter saturates
        ex_valid   = 1'b1;
        ex_pc      = '0;
        ex_pc_next = 36'd5;
        repeat ((1 << CNT_W) + 3) tick();
        ex_valid = 1'b0;
        check_state("saturate", 1'b0, 64'd5, 1'b1, 1'b0, 64'((1 << CNT_W) - 1));
        tick();
        tick();
        check_state("sat_resume", 1'b1, 64'd5, 1'b0, 1'b0, 64'((1 << CNT_W) - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
